ram_dp_be: RTL
==============

// Module: ram_dp_be
// PURPOSE
//  Parametrised simple-dual-port RAM (1 write port, 1 read port) with per-byte write enables.
//  Registered read with valid strobe; write-first bypass; zero-fill sweep after reset.
//  Successor to the flat single-port DFF RAM; serves as register-file/scratch memory beside the ALU.
// PARAMETERS
//  DATA_WIDTH  32   word width in bits; must be a multiple of 8
//  WORDS       128  number of words; need not be a power of two (>=2)
//  (local) AW = $clog2(WORDS) address width; NB = DATA_WIDTH/8 byte lanes
// PORTS
//  clk       in   1    single clock, all state on rising edge
//  reset     in   1    asynchronous, active-low reset
//  wr_en     in   1    write request, sampled at clk edge
//  wr_addr   in   AW   write word address
//  wr_data   in   DW   write data
//  wr_be     in   NB   byte enables; bit b covers wr_data[8b+7:8b]
//  rd_en     in   1    read request, sampled at clk edge
//  rd_addr   in   AW   read word address
//  rd_data   out  DW   registered read data
//  rd_valid  out  1    one-cycle strobe: rd_data updated this cycle
//  busy      out  1    high during post-reset zero-fill sweep
//  rd_perr   out  1    parity error flag, qualified by rd_valid (0 when feature off)
//  par_inj   in   1    present only with RAM_PARITY_EN: corrupt stored parity of byte 0
// BEHAVIOUR
//  Reset (reset=0, async): state=INIT, ptr=0, busy=1, rd_data=0, rd_valid=0, rd_perr=0.
//   Array has no async reset; its contents are defined by the sweep.
//  FSM INIT: each edge writes 0 to mem[ptr], ptr++; after writing ptr=WORDS-1 -> RUN, busy=0.
//   Sweep = exactly WORDS edges after reset release; busy falls after edge WORDS.
//   wr_en/rd_en ignored in INIT; rd_valid stays 0. No other transitions; RUN holds until reset.
//  RUN write: wr_en=1 -> byte b of mem[wr_addr] <= wr_data byte b iff wr_be[b]; other bytes kept.
//   wr_be=0 with wr_en=1: no change. wr_addr>=WORDS: write dropped.
//  RUN read: rd_en=1 at edge N -> rd_data=mem[rd_addr] and rd_valid=1 after edge N (latency 1).
//   rd_en=0: rd_valid=0, rd_data holds last value. rd_addr>=WORDS: rd_data=0, rd_valid=1.
//   Back-to-back reads: one result per cycle, no bubbles.
//  Same-edge write+read, same address: write-first; rd_data = old word with enabled bytes replaced
//   by wr_data (per-byte bypass). Different addresses: independent.
//  Reset mid-operation: in-flight read discarded (rd_valid=0 immediately), full sweep repeats.
// CONFIGURATION
//  RAM_PARITY_EN defined: one even-parity bit stored per byte, computed from byte written
//   (sweep stores 0). On read, parity recomputed per byte; rd_perr = OR of mismatches, registered
//   with rd_data, valid only with rd_valid; bypassed reads use fresh parity (never flag).
//   par_inj=1 during a write with wr_be[0]=1 stores inverted parity for byte 0.
//  RAM_PARITY_EN undefined: no parity storage, no par_inj port, rd_perr tied 0.
// TESTING
//  Release reset, poll busy -> busy=1 for exactly 128 cycles; then read all addrs -> all 0x00000000.
//  Write 0xDEADBEEF be=1111 @5, then 0x000000AA be=0001 @5, read @5 -> 0xDEADBEAA, rd_valid 1 cycle.
//  Same edge: write 0x11223344 be=1100 @9 (old 0) and read @9 -> rd_data=0x11220000.
//  Reads @1,@2,@3 on consecutive edges after writing 1,2,3 -> rd_data 1,2,3 on 3 consecutive cycles.
//  Assert reset mid-read stream -> rd_valid=0 at once, busy=1, data @5 reads 0 after new sweep.
//  RAM_PARITY_EN: write 0x55 be=0001 par_inj=1 @7, read @7 -> rd_perr=1; rewrite par_inj=0 -> 0.

Source files
------------

// File: rtl/ram_dp_be.sv
// ram_dp_be -- simple-dual-port RAM (one write port, one read port) with
// per-byte write enables, used as register-file / scratch memory beside the ALU.
//
// Behaviour summary:
//   * After reset is released, an INIT sweep writes zero to every word, one word
//     per clock, for exactly WORDS edges. busy is high during the sweep, and
//     requests on either port are ignored while it runs.
//   * In RUN, a write updates only the byte lanes selected by wr_be.
//   * A read has a latency of one clock. rd_valid is a one-cycle strobe.
//   * When a write and a read hit the same address on the same edge, the
//     written bytes are forwarded lane by lane (write-first).
//
// Optional feature (compile-time macro RAM_PARITY_EN):
//   Stores one even-parity bit per byte. rd_perr flags a stored/recomputed
//   mismatch. The par_inj input corrupts the parity stored for byte 0.
//   Without the macro there is no parity storage, no par_inj port, and
//   rd_perr is constant 0.
//
// Ports:
//   clk       in   1   clock, all state on rising edge
//   reset     in   1   asynchronous, active-low reset
//   wr_en     in   1   write request
//   wr_addr   in   AW  write word address (out-of-range writes are dropped)
//   wr_data   in   DW  write data
//   wr_be     in   NB  byte enables, bit b covers wr_data[8b+7:8b]
//   rd_en     in   1   read request
//   rd_addr   in   AW  read word address (out-of-range reads return 0)
//   rd_data   out  DW  registered read data, holds when no read
//   rd_valid  out  1   rd_data updated this cycle
//   busy      out  1   zero-fill sweep in progress
//   rd_perr   out  1   parity error, qualified by rd_valid
//   par_inj   in   1   (RAM_PARITY_EN only) invert stored parity of byte 0
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 128,
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_be,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
`ifdef RAM_PARITY_EN
  input  logic                  par_inj,
`endif
  output logic                  rd_perr
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0]   WORDS_EXT = (AW + 1)'(WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  // Even parity of one byte: the stored bit makes the 9-bit group even.
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [AW-1:0]           ptr_r, ptr_nxt_s;
  logic                    busy_r, busy_nxt_s;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic                    wr_in_range_s, rd_in_range_s;
  logic                    mem_we_s;
  logic [AW-1:0]           mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_data_s;
  logic [NB-1:0]           mem_be_s;

  logic [DATA_WIDTH-1:0]   rd_word_s, rd_next_s;
  logic [NB-1:0]           byp_s;
  logic                    rd_err_s;

  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    rd_valid_r, rd_perr_r;

  assign wr_in_range_s = ({1'b0, wr_addr} < WORDS_EXT);
  assign rd_in_range_s = ({1'b0, rd_addr} < WORDS_EXT);

  // FSM state, sweep pointer and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
      ptr_r   <= {AW{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // FSM next-state: sweep every word once, then stay in RUN until reset
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      ST_INIT: begin
        if (ptr_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
          ptr_nxt_s   = {AW{1'b0}};
          busy_nxt_s  = 1'b0;
        end else begin
          ptr_nxt_s  = ptr_r + AW'(1);
          busy_nxt_s = 1'b1;
        end
      end
      ST_RUN: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = ST_INIT;
        ptr_nxt_s   = {AW{1'b0}};
        busy_nxt_s  = 1'b1;
      end
    endcase
  end

  // Array write-port mux: the sweep owns the port in INIT, the user owns it in RUN
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = wr_addr;
    mem_data_s = wr_data;
    mem_be_s   = wr_be;
    case (state_r)
      ST_INIT: begin
        mem_we_s   = 1'b1;
        mem_addr_s = ptr_r;
        mem_data_s = {DATA_WIDTH{1'b0}};
        mem_be_s   = {NB{1'b1}};
      end
      ST_RUN: begin
        mem_we_s = wr_en & wr_in_range_s;
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Data array, byte-lane writes (no reset: the sweep defines contents)
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be_s[b]) begin
          mem[mem_addr_s][8*b +: 8] <= mem_data_s[8*b +: 8];
        end
      end
    end
  end

  // Read-side word: stored word with same-edge written bytes forwarded
  always_comb begin
    rd_word_s = mem[rd_addr];
    rd_next_s = {DATA_WIDTH{1'b0}};
    byp_s     = {NB{1'b0}};
    if (rd_in_range_s) begin
      for (int b = 0; b < NB; b++) begin
        byp_s[b] = (state_r == ST_RUN) & wr_en & wr_in_range_s &
                   (wr_addr == rd_addr) & wr_be[b];
        if (byp_s[b]) begin
          rd_next_s[8*b +: 8] = wr_data[8*b +: 8];
        end else begin
          rd_next_s[8*b +: 8] = rd_word_s[8*b +: 8];
        end
      end
    end else begin
      rd_next_s = {DATA_WIDTH{1'b0}};
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [WORDS];
  logic [NB-1:0] par_wdata_s;

  // Parity to store; injection only applies to a user write of byte 0
  always_comb begin
    par_wdata_s = {NB{1'b0}};
    for (int b = 0; b < NB; b++) begin
      par_wdata_s[b] = par8(mem_data_s[8*b +: 8]);
    end
    if ((state_r == ST_RUN) && par_inj) begin
      par_wdata_s[0] = ~par_wdata_s[0];
    end else begin
      par_wdata_s[0] = par_wdata_s[0];
    end
  end

  // Parity array, written in lockstep with the data array
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be_s[b]) begin
          par_mem[mem_addr_s][b] <= par_wdata_s[b];
        end
      end
    end
  end

  // Parity check; forwarded bytes carry fresh data and are never flagged
  always_comb begin
    rd_err_s = 1'b0;
    if (rd_in_range_s) begin
      for (int b = 0; b < NB; b++) begin
        if (!byp_s[b] && (par_mem[rd_addr][b] != par8(rd_word_s[8*b +: 8]))) begin
          rd_err_s = 1'b1;
        end
      end
    end else begin
      rd_err_s = 1'b0;
    end
  end
`else
  assign rd_err_s = 1'b0;
`endif

  // Registered read port; rd_data holds its value when no read is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      rd_perr_r  <= 1'b0;
    end else if ((state_r == ST_RUN) && rd_en) begin
      rd_data_r  <= rd_next_s;
      rd_valid_r <= 1'b1;
      rd_perr_r  <= rd_err_s;
    end else begin
      rd_valid_r <= 1'b0;
      rd_perr_r  <= 1'b0;
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_perr  = rd_perr_r;
  assign busy     = busy_r;

endmodule
